// File: rtl/wb_write_arbiter.sv
// wb_write_arbiter: GPR write-port arbiter merging WB-stage writes with late results via a FIFO and pending scoreboard
// Optional macro WB_ARB_BYPASS_EN: a late result skips the empty FIFO when the slot is free.
module wb_write_arbiter #(
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        pipe_we,
    input  logic [4:0]  pipe_a3,
    input  logic [31:0] pipe_wd,
    output logic        pipe_stall,
    input  logic        late_valid,
    output logic        late_ready,
    input  logic [4:0]  late_a3,
    input  logic [31:0] late_wd,
    input  logic        rsv_valid,
    input  logic [4:0]  rsv_a3,
    input  logic [4:0]  q_a1,
    input  logic [4:0]  q_a2,
    output logic        busy1,
    output logic        busy2,
    output logic        RegWrite,
    output logic [4:0]  A3,
    output logic [31:0] Wd
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [SW-1:0] SMAX = SW'(STARVE_MAX);
    logic [4:0]    r_fa3 [DEPTH];
    logic [31:0]   r_fwd [DEPTH];
    logic [AW-1:0] r_wp, r_rp;
    logic [CW-1:0] r_cnt;
    logic [SW-1:0] r_starve;
    logic [31:0]   r_pend;
    logic          w_empty, w_pipe_go, w_drain, w_byp, w_push, w_late_slot;
    logic [4:0]    w_sa3;
    logic [31:0]   w_swd, w_pend_n;
`ifdef WB_ARB_BYPASS_EN
    assign w_byp = w_empty && !w_pipe_go && late_valid;
`else
    assign w_byp = 1'b0;
`endif
    always_comb begin
        w_empty     = r_cnt == '0;
        late_ready  = r_cnt != FULL;
        pipe_stall  = !w_empty && r_starve == SMAX;
        w_pipe_go   = !pipe_stall && pipe_we && pipe_a3 != 5'd0;
        w_drain     = !w_empty && !w_pipe_go;
        w_push      = late_valid && late_ready && !w_byp;
        w_late_slot = w_drain || w_byp;
        w_sa3       = w_byp ? late_a3 : r_fa3[r_rp];
        w_swd       = w_byp ? late_wd : r_fwd[r_rp];
        // a same-edge reservation must survive the clear of an older result
        w_pend_n    = (r_pend & ~(w_late_slot ? 32'd1 << w_sa3 : 32'd0))
                    | ((rsv_valid && rsv_a3 != 5'd0) ? 32'd1 << rsv_a3 : 32'd0);
        busy1       = r_pend[q_a1];
        busy2       = r_pend[q_a2];
    end
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fa3[r_wp] <= late_a3;
            r_fwd[r_wp] <= late_wd;
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            RegWrite <= 1'b0;
            A3       <= '0;
            Wd       <= '0;
            r_wp     <= '0;
            r_rp     <= '0;
            r_cnt    <= '0;
            r_starve <= '0;
            r_pend   <= '0;
        end else begin
            RegWrite <= w_pipe_go || (w_late_slot && w_sa3 != 5'd0);
            if (w_pipe_go) begin
                A3 <= pipe_a3;
                Wd <= pipe_wd;
            end else if (w_late_slot) begin
                A3 <= w_sa3;
                Wd <= w_swd;
            end
            if (w_push)
                r_wp <= r_wp + 1'b1;
            if (w_drain)
                r_rp <= r_rp + 1'b1;
            r_cnt    <= r_cnt + CW'(w_push) - CW'(w_drain);
            r_starve <= (w_empty || w_drain) ? '0 : r_starve + 1'b1;
            r_pend   <= w_pend_n;
        end
    end
endmodule

// File: tb/tb_wb_write_arbiter.sv
// tb_wb_write_arbiter: vector table plus directed and random sequences for wb_write_arbiter
module tb_wb_write_arbiter;
`ifdef WB_ARB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        rst, pipe_we, pipe_stall, late_valid, late_ready, rsv_valid;
    logic        busy1, busy2, RegWrite;
    logic [4:0]  pipe_a3, late_a3, rsv_a3, q_a1, q_a2, A3;
    logic [31:0] pipe_wd, late_wd, Wd;
    int          n_chk = 0;
    int          n_fail = 0;

    wb_write_arbiter #(.DEPTH(4), .STARVE_MAX(8)) dut (
        .clk(clk), .rst(rst),
        .pipe_we(pipe_we), .pipe_a3(pipe_a3), .pipe_wd(pipe_wd), .pipe_stall(pipe_stall),
        .late_valid(late_valid), .late_ready(late_ready), .late_a3(late_a3), .late_wd(late_wd),
        .rsv_valid(rsv_valid), .rsv_a3(rsv_a3), .q_a1(q_a1), .q_a2(q_a2),
        .busy1(busy1), .busy2(busy2), .RegWrite(RegWrite), .A3(A3), .Wd(Wd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst, pwe;
        logic [4:0]  pa3;
        logic [31:0] pwd;
        logic        lv;
        logic [4:0]  la3;
        logic [31:0] lwd;
        logic        rv;
        logic [4:0]  ra3, q1, q2;
        logic        rw;
        logic [4:0]  a3;
        logic [31:0] wd;
        logic        b1, b2, lr, ps, cd;
    } vec_t;

    vec_t        tv [13];
    logic [31:0] gold [32];
    logic [31:0] img [32];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        rst = 1'b0; pipe_we = 1'b0; pipe_a3 = '0; pipe_wd = '0;
        late_valid = 1'b0; late_a3 = '0; late_wd = '0; rsv_valid = 1'b0; rsv_a3 = '0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time expired, expected $finish");
        $fatal(1);
    end

    initial begin
        logic p_hold, l_hold;
        idle();
        q_a1 = '0; q_a2 = '0;
        //          rst  pwe  pa3   pwd           lv   la3   lwd            rv   ra3   q1    q2    rw   a3    wd            b1   b2   lr   ps   cd
        tv[0]  = '{1'b1,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0, 1'b0,5'd0,32'h0,       1'b0,1'b0,1'b1,1'b0,1'b1};
        tv[1]  = '{1'b0,1'b1,5'd5,32'h1234,    1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0, 1'b1,5'd5,32'h1234,    1'b0,1'b0,1'b1,1'b0,1'b1};
        tv[2]  = '{1'b0,1'b1,5'd0,32'hffff,    1'b0,5'd0,32'h0,        1'b0,5'd0,5'd0,5'd0, 1'b0,5'd5,32'h1234,    1'b0,1'b0,1'b1,1'b0,1'b1};
        tv[3]  = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b1,5'd9,5'd9,5'd5, 1'b0,5'd5,32'h1234,    1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[4]  = '{1'b0,1'b1,5'd3,32'h33,      1'b1,5'd9,32'haaaa,     1'b0,5'd0,5'd9,5'd5, 1'b1,5'd3,32'h33,      1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[5]  = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b0,5'd0,5'd9,5'd5, 1'b1,5'd9,32'haaaa,    1'b0,1'b0,1'b1,1'b0,1'b1};
        tv[6]  = '{1'b0,1'b1,5'd4,32'h44,      1'b1,5'd7,32'h77,       1'b1,5'd7,5'd7,5'd9, 1'b1,5'd4,32'h44,      1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[7]  = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b1,5'd7,5'd7,5'd9, 1'b1,5'd7,32'h77,      1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[8]  = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b0,5'd0,5'd7,5'd0, 1'b0,5'd7,32'h77,      1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[9]  = '{1'b0,1'b1,5'd2,32'h22,      1'b1,5'd0,32'hdead,     1'b0,5'd0,5'd7,5'd0, 1'b1,5'd2,32'h22,      1'b1,1'b0,1'b1,1'b0,1'b1};
        tv[10] = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b0,5'd0,5'd7,5'd0, 1'b0,5'd0,32'h0,       1'b1,1'b0,1'b1,1'b0,1'b0};
        tv[11] = '{1'b1,1'b1,5'd6,32'h66,      1'b1,5'd8,32'h88,       1'b1,5'd8,5'd7,5'd8, 1'b0,5'd0,32'h0,       1'b0,1'b0,1'b1,1'b0,1'b1};
        tv[12] = '{1'b0,1'b0,5'd0,32'h0,       1'b0,5'd0,32'h0,        1'b0,5'd0,5'd7,5'd8, 1'b0,5'd0,32'h0,       1'b0,1'b0,1'b1,1'b0,1'b1};
        for (int i = 0; i < 13; i++) begin
            rst = tv[i].rst; pipe_we = tv[i].pwe; pipe_a3 = tv[i].pa3; pipe_wd = tv[i].pwd;
            late_valid = tv[i].lv; late_a3 = tv[i].la3; late_wd = tv[i].lwd;
            rsv_valid = tv[i].rv; rsv_a3 = tv[i].ra3; q_a1 = tv[i].q1; q_a2 = tv[i].q2;
            tick();
            chk($sformatf("v%0d.RegWrite", i), 32'(RegWrite), 32'(tv[i].rw));
            chk($sformatf("v%0d.busy1", i), 32'(busy1), 32'(tv[i].b1));
            chk($sformatf("v%0d.busy2", i), 32'(busy2), 32'(tv[i].b2));
            chk($sformatf("v%0d.late_ready", i), 32'(late_ready), 32'(tv[i].lr));
            chk($sformatf("v%0d.pipe_stall", i), 32'(pipe_stall), 32'(tv[i].ps));
            if (tv[i].cd) begin
                chk($sformatf("v%0d.A3", i), 32'(A3), 32'(tv[i].a3));
                chk($sformatf("v%0d.Wd", i), Wd, tv[i].wd);
            end
        end
        // late result latency and busy release, with and without bypass
        idle(); rsv_valid = 1'b1; rsv_a3 = 5'd9; q_a1 = 5'd9;
        tick();
        chk("lat.busy_rsv", 32'(busy1), 32'd1);
        idle(); late_valid = 1'b1; late_a3 = 5'd9; late_wd = 32'haaaa;
        tick();
        chk("lat.n1_RegWrite", 32'(RegWrite), 32'(BYP));
        chk("lat.n1_busy", 32'(busy1), 32'(!BYP));
        idle();
        tick();
        chk("lat.n2_RegWrite", 32'(RegWrite), 32'(!BYP));
        chk("lat.n2_A3", 32'(A3), 32'd9);
        chk("lat.n2_Wd", Wd, 32'haaaa);
        chk("lat.n2_busy", 32'(busy1), 32'd0);
        // fill the FIFO under constant pipe pressure until starvation forces a drain
        for (int k = 1; k <= 9; k++) begin
            idle(); pipe_we = 1'b1; pipe_a3 = 5'(9 + k); pipe_wd = 32'(k);
            if (k <= 4) begin
                late_valid = 1'b1; late_a3 = 5'(19 + k); late_wd = 32'h100 + 32'(k);
            end
            tick();
            chk($sformatf("starve%0d.A3", k), 32'(A3), 32'(9 + k));
            chk($sformatf("starve%0d.late_ready", k), 32'(late_ready), 32'(k < 4));
            chk($sformatf("starve%0d.pipe_stall", k), 32'(pipe_stall), 32'(k == 9));
        end
        idle(); pipe_we = 1'b1; pipe_a3 = 5'd30; pipe_wd = 32'h30;
        tick();
        chk("starve.drain_RegWrite", 32'(RegWrite), 32'd1);
        chk("starve.drain_A3", 32'(A3), 32'd20);
        chk("starve.drain_Wd", Wd, 32'h101);
        chk("starve.drain_stall", 32'(pipe_stall), 32'd0);
        chk("starve.drain_ready", 32'(late_ready), 32'd1);
        tick();
        chk("starve.retry_A3", 32'(A3), 32'd30);
        chk("starve.retry_Wd", Wd, 32'h30);
        // reset with 3 buffered entries and two reservations
        idle(); pipe_we = 1'b1; pipe_a3 = 5'd31; pipe_wd = 32'h31; rsv_valid = 1'b1; rsv_a3 = 5'd3;
        tick();
        rsv_a3 = 5'd7; pipe_wd = 32'h32; q_a1 = 5'd3; q_a2 = 5'd7;
        tick();
        chk("rst.pre_busy3", 32'(busy1), 32'd1);
        chk("rst.pre_busy7", 32'(busy2), 32'd1);
        rst = 1'b1; late_valid = 1'b1; late_a3 = 5'd8; late_wd = 32'h88;
        tick();
        chk("rst.RegWrite", 32'(RegWrite), 32'd0);
        chk("rst.busy3", 32'(busy1), 32'd0);
        chk("rst.busy7", 32'(busy2), 32'd0);
        chk("rst.late_ready", 32'(late_ready), 32'd1);
        chk("rst.pipe_stall", 32'(pipe_stall), 32'd0);
        idle();
        for (int k = 0; k < 6; k++) begin
            tick();
            chk($sformatf("rst.stale%0d", k), 32'(RegWrite), 32'd0);
        end
        for (int r = 0; r < 32; r++) begin
            q_a1 = 5'(r);
            #1;
            chk($sformatf("rst.busy_r%0d", r), 32'(busy1), 32'd0);
        end
        // random traffic: pipe owns x0-x15, late results own x16-x31 (plus dropped x0)
        for (int r = 0; r < 32; r++) begin
            gold[r] = '0;
            img[r] = '0;
        end
        p_hold = 1'b0; l_hold = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (!p_hold) begin
                pipe_we = c < 350 && $urandom_range(2, 0) != 0;
                pipe_a3 = 5'($urandom_range(15, 0));
                pipe_wd = $urandom;
            end
            if (!l_hold) begin
                late_valid = c < 350 && $urandom_range(1, 0) != 0;
                late_a3 = $urandom_range(7, 0) == 0 ? 5'd0 : 5'($urandom_range(31, 16));
                late_wd = $urandom;
            end
            rsv_valid = $urandom_range(3, 0) == 0;
            rsv_a3 = 5'($urandom_range(31, 0));
            p_hold = pipe_we && pipe_stall;
            l_hold = late_valid && !late_ready;
            if (pipe_we && !pipe_stall && pipe_a3 != 5'd0)
                gold[pipe_a3] = pipe_wd;
            if (late_valid && late_ready && late_a3 != 5'd0)
                gold[late_a3] = late_wd;
            tick();
            if (RegWrite) begin
                chk("rand.write_x0", 32'(A3 == 5'd0), 32'd0);
                img[A3] = Wd;
            end
        end
        idle();
        for (int c = 0; c < 12; c++) begin
            tick();
            if (RegWrite) begin
                chk("rand.write_x0", 32'(A3 == 5'd0), 32'd0);
                img[A3] = Wd;
            end
        end
        for (int r = 1; r < 32; r++)
            chk($sformatf("rand.gpr_x%0d", r), img[r], gold[r]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
